mc_control_fsm: RTL and testbench

//  Multi-cycle main control FSM. Decodes the 6-bit opcode and sequences each

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_decode.sv | 71 +++++++
 rtl/mc_control_fsm.sv | 129 ++++++++++++
 tb/tb_mc_control_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared constants for the multi-cycle main control FSM: 4-bit state
//   encodings, opcode values, ALU-op and datapath mux-select codes, and the
//   packed control word produced by the state decoder.
//   Optional build macro consumed by the FSM: MC_MEM_WAIT_EN.
package mc_ctrl_pkg;

    localparam int OP_W_DEF    = 6;
    localparam int ALUOP_W_DEF = 2;

    // States (4-bit). Encodings 13..15 are unreachable and recover to IDLE.
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
//   Pure combinational state -> control-word decoder (Moore outputs).
//   Ports:
//     state  in   4       current FSM state
//     ctrl   out  ctrl_t  raw control word (memory-wait qualification is
//                         applied by the FSM top, not here)
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle main control FSM. Sequences each instruction through
//   fetch/decode/execute/memory/writeback and drives the datapath mux
//   selects and write enables.
//   Build macro: MC_MEM_WAIT_EN -- FETCH/MEMRD/MEMWR stall until mem_ready,
//   with pc_write/ir_write/mem_write asserted only in the completing cycle.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     opcode[OP_W]               instr[31:26], sampled in DECODE/MEMADR only
//     zero                       ALU zero flag (BRANCH)
//     mem_ready                  memory done (MC_MEM_WAIT_EN builds only)
//     iord, alu_src_a, alu_src_b, mem_to_reg, reg_dst, pc_src, alu_op
//                                datapath selects
//     ir_write, mem_write, reg_write, pc_en   write enables
//     illegal_op                 asserted while in DECODE with unknown opcode
//
//   state  | meaning
//   IDLE   | after reset, all outputs 0
//   FETCH  | IR <= mem[PC], PC <= PC+4
//   DECODE | register read, branch target into ALUOut, opcode dispatch
//   MEMADR | load/store address = A + sign-ext imm
//   MEMRD  | memory read at ALUOut
//   MEMWB  | rt <= MDR
//   MEMWR  | memory write at ALUOut
//   EXEC   | R-type ALU operation
//   ALUWB  | rd <= ALUOut
//   BRANCH | compare A-B, PC <= ALUOut when zero
//   ADDIEX | A + sign-ext imm
//   ADDIWB | rt <= ALUOut
//   JUMP   | PC <= jump target
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               pc_en,
    output logic               illegal_op
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    ctrl_t      ctrl;
    logic       mem_done;
    logic       mem_state;
    logic       wr_ok;

`ifdef MC_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            // IR is stable here, so anything other than LW is the store.
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = mem_done ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = mem_done ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Stalled memory states keep their selects but hold back the writes
    // until the access completes.
    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign wr_ok     = !mem_state || mem_done;

    assign iord       = ctrl.iord;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign ir_write   = ctrl.ir_write & wr_ok;
    assign mem_write  = ctrl.mem_write & wr_ok;
    assign reg_write  = ctrl.reg_write;
    assign pc_en      = (ctrl.pc_write & wr_ok) | (ctrl.branch & zero);
    assign illegal_op = (state == S_DECODE) && !is_known_op(opcode);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm: reset behaviour, a table of
//   per-opcode latency / final-cycle vectors, asynchronous reset mid-store,
//   optional memory-wait stalls (MC_MEM_WAIT_EN), and randomized instruction
//   streams checked cycle by cycle against a per-opcode output-sequence model.
module tb_mc_control_fsm;

    typedef logic [15:0] word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, alu_src_a, mem_to_reg, reg_dst;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       ir_write, mem_write, reg_write, pc_en, illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    mc_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .pc_en      (pc_en),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // {iord, src_a, src_b[2], mem_to_reg, reg_dst, pc_src[2], alu_op[2],
    //  ir_write, mem_write, reg_write, pc_en, illegal_op}
    word_t act;
    assign act = {iord, alu_src_a, alu_src_b, mem_to_reg, reg_dst, pc_src, alu_op,
                  ir_write, mem_write, reg_write, pc_en, illegal_op};

    localparam word_t W_IDLE     = 16'h0000;
    localparam word_t W_FETCH    = {1'b0,1'b0,2'b01,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0};
    localparam word_t W_FETCH_HD = {1'b0,1'b0,2'b01,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam word_t W_DECODE   = {1'b0,1'b0,2'b11,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam word_t W_DEC_ILL  = {1'b0,1'b0,2'b11,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1};
    localparam word_t W_ADDR     = {1'b0,1'b1,2'b10,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam word_t W_MEMRD    = {1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam word_t W_MEMWB    = {1'b0,1'b0,2'b00,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
    localparam word_t W_MEMWR    = {1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0};
    localparam word_t W_EXEC     = {1'b0,1'b1,2'b00,1'b0,1'b0,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam word_t W_ALUWB    = {1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
    localparam word_t W_BR0      = {1'b0,1'b1,2'b00,1'b0,1'b0,2'b01,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam word_t W_BR1      = {1'b0,1'b1,2'b00,1'b0,1'b0,2'b01,2'b01,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam word_t W_ADDIWB   = {1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
    localparam word_t W_JUMP     = {1'b0,1'b0,2'b00,1'b0,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};

    word_t exp_q[$];

    // Reference: the full per-cycle output sequence of one instruction.
    function automatic void build_seq(input logic [5:0] op, input logic z);
        exp_q.delete();
        exp_q.push_back(W_FETCH);
        case (op)
            6'b100011: begin exp_q.push_back(W_DECODE); exp_q.push_back(W_ADDR);
                             exp_q.push_back(W_MEMRD);  exp_q.push_back(W_MEMWB); end
            6'b101011: begin exp_q.push_back(W_DECODE); exp_q.push_back(W_ADDR);
                             exp_q.push_back(W_MEMWR); end
            6'b000000: begin exp_q.push_back(W_DECODE); exp_q.push_back(W_EXEC);
                             exp_q.push_back(W_ALUWB); end
            6'b001000: begin exp_q.push_back(W_DECODE); exp_q.push_back(W_ADDR);
                             exp_q.push_back(W_ADDIWB); end
            6'b000100: begin exp_q.push_back(W_DECODE);
                             exp_q.push_back(z ? W_BR1 : W_BR0); end
            6'b000010: begin exp_q.push_back(W_DECODE); exp_q.push_back(W_JUMP); end
            default:         exp_q.push_back(W_DEC_ILL);
        endcase
    endfunction

    task automatic check(input string name, input word_t a, input word_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at #1 after the edge that put the FSM in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic z);
        opcode = op;
        zero   = z;
        build_seq(op, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step();
`ifndef MC_MEM_WAIT_EN
            mem_ready = 1'($urandom_range(0, 1));
            #1;
`endif
            check($sformatf("seq op=%b z=%0d c%0d", op, z, i), act, exp_q[i]);
        end
        step();
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         lat;
        word_t      last;
    } vec_t;

    vec_t       vt[8];
    logic [5:0] legal[6];

    initial begin
        word_t prev;
        int    cyc;

        vt[0] = '{6'b100011, 1'b0, 5, W_MEMWB};
        vt[1] = '{6'b101011, 1'b0, 4, W_MEMWR};
        vt[2] = '{6'b000000, 1'b0, 4, W_ALUWB};
        vt[3] = '{6'b001000, 1'b0, 4, W_ADDIWB};
        vt[4] = '{6'b000100, 1'b1, 3, W_BR1};
        vt[5] = '{6'b000100, 1'b0, 3, W_BR0};
        vt[6] = '{6'b000010, 1'b0, 3, W_JUMP};
        vt[7] = '{6'b111111, 1'b0, 2, W_DEC_ILL};
        legal[0] = 6'b000000; legal[1] = 6'b100011; legal[2] = 6'b101011;
        legal[3] = 6'b000100; legal[4] = 6'b001000; legal[5] = 6'b000010;

        // Reset, then IDLE with all outputs low, then FETCH.
        #12;
        check("reset idle", act, W_IDLE);
        rst_n = 1'b1;
        #1;
        check("idle after release", act, W_IDLE);
        step();
        check("first fetch", act, W_FETCH);

        // Table: latency back to FETCH and outputs of the last cycle.
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            opcode = vt[k].op;
            zero   = vt[k].z;
            cyc    = 1;
            prev   = act;
            step();
            while (act !== W_FETCH && cyc < 12) begin
                prev = act;
                cyc++;
                step();
            end
            check($sformatf("latency op=%b", vt[k].op), word_t'(cyc), word_t'(vt[k].lat));
            check($sformatf("last op=%b z=%0d", vt[k].op, vt[k].z), prev, vt[k].last);
        end

        // SW with async reset asserted during MEMWR.
        opcode = 6'b101011;
        step(); step(); step();
        check("sw memwr", act, W_MEMWR);
        #2 rst_n = 1'b0;
        #1;
        check("async reset drop", act, W_IDLE);
        step();
        check("reset held idle", act, W_IDLE);
        rst_n = 1'b1;
        #1;
        check("idle after 2nd release", act, W_IDLE);
        step();
        check("fetch after 2nd reset", act, W_FETCH);

`ifdef MC_MEM_WAIT_EN
        // FETCH stalls while memory is busy; writes only on completion.
        opcode    = 6'b000010;
        mem_ready = 1'b0;
        #1;
        check("fetch stall c0", act, W_FETCH_HD);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("fetch stall c%0d", i), act, W_FETCH_HD);
        end
        mem_ready = 1'b1;
        #1;
        check("fetch complete", act, W_FETCH);
        step();
        check("decode after stall", act, W_DECODE);
        step();
        check("jump after stall", act, W_JUMP);
        step();
        check("fetch after jump", act, W_FETCH);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            run_instr(op, 1'($urandom_range(0, 1)));
        end
        mem_ready = 1'b1;
        #1;
        check("final fetch", act, W_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
